// File: rtl/temp_top_pkg.sv
// Shared decode types for the single-cycle MIPS subset core.
// Opcode/funct encodings, ALU controls and instruction fields.
package mipspkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        F_ADD = 6'h20,
        F_SUB = 6'h22,
        F_AND = 6'h24,
        F_OR  = 6'h25,
        F_XOR = 6'h26,
        F_NOR = 6'h27,
        F_SLT = 6'h2A
    } funct_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_LUI
    } alu_t;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/temp_top_if.sv
// Observation bundle exported by the processor top.
// The core drives it; the bench only watches it.
interface proc_memory;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_we;

    modport master (
        output pc, instr, dmem_addr,
        output dmem_wdata, dmem_rdata, dmem_we
    );

    modport slave (
        input pc, instr, dmem_addr,
        input dmem_wdata, dmem_rdata, dmem_we
    );
endinterface

// File: rtl/temp_top_mem.sv
// Program-memory holding register and the word-addressed data RAM.
// The bench loads pminst.instr directly; reset only clears it.
module progmem (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_instr
);
    logic [31:0] instr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            instr <= '0;
        end
    end

    assign o_instr = instr;
endmodule

module datamem #(
    parameter int WORDS = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    // Contents survive reset; only power-up starts from zero.
    logic [31:0] RAM [0:WORDS-1] = '{default: '0};

    always_ff @(posedge i_clk) begin
        if (!i_reset && i_we) begin
            RAM[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = RAM[i_idx];
endmodule

// File: rtl/temp_top_mips.sv
// Single-cycle MIPS subset: combinational controller plus datapath.
// Everything is decoded from the held instruction each cycle.
module controller
    import mipspkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_alu_src,
    output logic       o_mem_write,
    output logic       o_mem_to_reg,
    output logic       o_branch,
    output logic       o_jump,
    output alu_t       o_alu_ctl
);
    always_comb begin
        o_reg_write  = 1'b0;
        o_reg_dst    = 1'b0;
        o_alu_src    = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        o_branch     = 1'b0;
        o_jump       = 1'b0;
        o_alu_ctl    = ALU_ADD;
        case (i_op)
            OP_RTYPE: begin
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
                case (i_funct)
                    F_ADD:   o_alu_ctl = ALU_ADD;
                    F_SUB:   o_alu_ctl = ALU_SUB;
                    F_AND:   o_alu_ctl = ALU_AND;
                    F_OR:    o_alu_ctl = ALU_OR;
                    F_XOR:   o_alu_ctl = ALU_XOR;
                    F_NOR:   o_alu_ctl = ALU_NOR;
                    F_SLT:   o_alu_ctl = ALU_SLT;
                    default: o_reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                o_reg_write = 1'b1;
                o_alu_src   = 1'b1;
            end
            OP_SLTI: begin
                o_reg_write = 1'b1;
                o_alu_src   = 1'b1;
                o_alu_ctl   = ALU_SLT;
            end
            OP_LUI: begin
                o_reg_write = 1'b1;
                o_alu_src   = 1'b1;
                o_alu_ctl   = ALU_LUI;
            end
            OP_LW: begin
                o_reg_write  = 1'b1;
                o_alu_src    = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            OP_SW: begin
                o_alu_src   = 1'b1;
                o_mem_write = 1'b1;
            end
            OP_BEQ:  o_branch = 1'b1;
            OP_J:    o_jump   = 1'b1;
            default: ;
        endcase
    end
endmodule

module datapath
    import mipspkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instr,
    input  logic        i_reg_write,
    input  logic        i_reg_dst,
    input  logic        i_alu_src,
    input  logic        i_mem_to_reg,
    input  logic        i_branch,
    input  logic        i_jump,
    input  alu_t        i_alu_ctl,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_alu,
    output logic [31:0] o_wdata
);
    instr_t      w_f;
    logic [31:0] r_pc;
    logic [31:0] w_rd1, w_rd2, w_imm, w_b;
    logic [31:0] w_alu, w_wd, w_pc4, w_next;
    logic [4:0]  w_wa;

    assign w_f   = i_instr;
    assign w_imm = sext16(i_instr[15:0]);
    assign w_wa  = i_reg_dst ? w_f.rd : w_f.rt;
    assign w_b   = i_alu_src ? w_imm : w_rd2;

    regfile rf (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_ra1  (w_f.rs),
        .i_ra2  (w_f.rt),
        .i_we   (i_reg_write),
        .i_wa   (w_wa),
        .i_wd   (w_wd),
        .o_rd1  (w_rd1),
        .o_rd2  (w_rd2)
    );

    always_comb begin
        w_alu = w_rd1 + w_b;
        case (i_alu_ctl)
            ALU_ADD: w_alu = w_rd1 + w_b;
            ALU_SUB: w_alu = w_rd1 - w_b;
            ALU_AND: w_alu = w_rd1 & w_b;
            ALU_OR:  w_alu = w_rd1 | w_b;
            ALU_XOR: w_alu = w_rd1 ^ w_b;
            ALU_NOR: w_alu = ~(w_rd1 | w_b);
            ALU_SLT: w_alu = {31'b0, $signed(w_rd1) < $signed(w_b)};
            ALU_LUI: w_alu = {w_b[15:0], 16'h0};
            default: w_alu = w_rd1 + w_b;
        endcase
    end

    assign w_wd  = i_mem_to_reg ? i_rdata : w_alu;
    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_next = w_pc4;
        if (i_jump) begin
            w_next = {w_pc4[31:28], i_instr[25:0], 2'b00};
        end else if (i_branch && (w_rd1 == w_rd2)) begin
            w_next = w_pc4 + {w_imm[29:0], 2'b00};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next;
        end
    end

    assign o_pc    = r_pc;
    assign o_alu   = w_alu;
    assign o_wdata = w_rd2;
endmodule

module mips
    import mipspkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic        o_we
);
    logic w_reg_write, w_reg_dst, w_alu_src;
    logic w_mem_to_reg, w_branch, w_jump;
    alu_t w_alu_ctl;

    controller c (
        .i_op        (i_instr[31:26]),
        .i_funct     (i_instr[5:0]),
        .o_reg_write (w_reg_write),
        .o_reg_dst   (w_reg_dst),
        .o_alu_src   (w_alu_src),
        .o_mem_write (o_we),
        .o_mem_to_reg(w_mem_to_reg),
        .o_branch    (w_branch),
        .o_jump      (w_jump),
        .o_alu_ctl   (w_alu_ctl)
    );

    datapath #(.RESET_PC(RESET_PC)) dp (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_instr     (i_instr),
        .i_reg_write (w_reg_write),
        .i_reg_dst   (w_reg_dst),
        .i_alu_src   (w_alu_src),
        .i_mem_to_reg(w_mem_to_reg),
        .i_branch    (w_branch),
        .i_jump      (w_jump),
        .i_alu_ctl   (w_alu_ctl),
        .i_rdata     (i_rdata),
        .o_pc        (o_pc),
        .o_alu       (o_addr),
        .o_wdata     (o_wdata)
    );
endmodule

// File: rtl/temp_top_regfile.sv
// 32x32 register file: two async read ports, one write port.
// Register 0 is never written, so it always reads zero.
module regfile (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] rfile [0:31];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                rfile[i] <= '0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            rfile[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'h0 : rfile[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'h0 : rfile[i_ra2];
endmodule

// File: rtl/temp_top.sv
// Processor top: core, program-memory register and data RAM.
// One instruction per clock, observed through p_f.
module temp_top
    import mipspkg::*;
#(
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic       clk,
    input  logic       reset,
    proc_memory.master p_f
);
    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0] w_instr, w_pc, w_addr, w_wdata, w_rdata;
    logic        w_we;

    progmem pminst (
        .i_clk  (clk),
        .i_reset(reset),
        .o_instr(w_instr)
    );

    mips #(.RESET_PC(RESET_PC)) mipsinst (
        .i_clk  (clk),
        .i_reset(reset),
        .i_instr(w_instr),
        .i_rdata(w_rdata),
        .o_pc   (w_pc),
        .o_addr (w_addr),
        .o_wdata(w_wdata),
        .o_we   (w_we)
    );

    datamem #(.WORDS(DMEM_WORDS)) dmeminst (
        .i_clk  (clk),
        .i_reset(reset),
        .i_we   (w_we),
        .i_idx  (w_addr[AW+1:2]),
        .i_wdata(w_wdata),
        .o_rdata(w_rdata)
    );

    // Hold the visible state quiet while reset is asserted.
    assign p_f.pc         = reset ? 32'h0 : w_pc;
    assign p_f.instr      = reset ? 32'h0 : w_instr;
    assign p_f.dmem_we    = reset ? 1'b0  : w_we;
    assign p_f.dmem_addr  = w_addr;
    assign p_f.dmem_wdata = w_wdata;
    assign p_f.dmem_rdata = w_rdata;
endmodule

// File: tb/tb_temp_top.sv
// Directed-vector bench for temp_top with a queue-based scoreboard.
// Stimulus pushes expectations; a monitor checks them after each edge.
module tb_temp_top;
    typedef enum {
        K_REG, K_RAM, K_PC, K_INSTR, K_RDATA, K_ADDR, K_WDATA, K_WE
    } kind_t;

    typedef struct {
        kind_t       k;
        int          idx;
        logic [31:0] v;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    proc_memory p_f();

    temp_top dut (
        .clk  (clk),
        .reset(reset),
        .p_f  (p_f)
    );

    task automatic expect_v(input kind_t k, input int idx,
                            input logic [31:0] v, input string nm);
        exp_t e;
        e.k = k;
        e.idx = idx;
        e.v = v;
        e.nm = nm;
        q.push_back(e);
    endtask

    // Load one instruction at the negedge, queue its effects, advance.
    task automatic run(input logic [31:0] ins, input int r,
                       input logic [31:0] v, input logic [31:0] npc,
                       input string nm);
        dut.pminst.instr = ins;
        expect_v(K_REG, r, v, nm);
        expect_v(K_PC, 0, npc, {nm, "_pc"});
        @(negedge clk);
    endtask

    function automatic logic [31:0] actual(input exp_t e);
        case (e.k)
            K_REG:   return dut.mipsinst.dp.rf.rfile[e.idx];
            K_RAM:   return dut.dmeminst.RAM[e.idx];
            K_PC:    return p_f.pc;
            K_INSTR: return p_f.instr;
            K_RDATA: return p_f.dmem_rdata;
            K_ADDR:  return p_f.dmem_addr;
            K_WDATA: return p_f.dmem_wdata;
            default: return {31'b0, p_f.dmem_we};
        endcase
    endfunction

    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                a = actual(e);
                checks++;
                if (a !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.nm, a, e.v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            expect_v(K_REG, i, 32'h0, $sformatf("rst_r%0d", i));
        end
        expect_v(K_PC, 0, 32'h0, "rst_pc");
        expect_v(K_INSTR, 0, 32'h0, "rst_instr");
        expect_v(K_WE, 0, 32'h0, "rst_we");
        @(negedge clk);
        reset = 1'b0;

        run(32'h8C051234, 5, 32'h0, 32'h04, "lw0");
        run(32'h00853FE0, 7, 32'h0, 32'h08, "add");
        run(32'h20642345, 4, 32'h2345, 32'h0C, "addi");
        run(32'h008537E2, 6, 32'h2345, 32'h10, "sub");
        run(32'h018D77E6, 14, 32'h0, 32'h14, "xor");
        run(32'h20062345, 6, 32'h2345, 32'h18, "addi_r6");
        expect_v(K_RAM, 13, 32'h2345, "sw_ram13");
        expect_v(K_ADDR, 0, 32'h1234, "sw_addr");
        expect_v(K_WDATA, 0, 32'h2345, "sw_wdata");
        expect_v(K_WE, 0, 32'h1, "sw_we");
        run(32'hAC061234, 6, 32'h2345, 32'h1C, "sw");
        expect_v(K_RDATA, 0, 32'h2345, "lw_rdata");
        run(32'h8C051234, 5, 32'h2345, 32'h20, "lw1");
        run(32'h2006FFFF, 6, 32'hFFFFFFFF, 32'h24, "addi_neg");
        run(32'h28C70001, 7, 32'h1, 32'h28, "slti");
        run(32'h00C747EA, 8, 32'h1, 32'h2C, "slt");
        run(32'h3C0F1234, 15, 32'h12340000, 32'h30, "lui");
        run(32'h20000005, 0, 32'h0, 32'h34, "r0_write");
        run(32'h10000003, 0, 32'h0, 32'h44, "beq_taken");
        run(32'h10A00003, 5, 32'h2345, 32'h48, "beq_not");
        run(32'h08000010, 0, 32'h0, 32'h40, "jump");
        run(32'h0085383F, 7, 32'h1, 32'h44, "bad_funct");
        expect_v(K_RAM, 5, 32'h12340000, "sw5_ram");
        run(32'hAC0F0014, 15, 32'h12340000, 32'h48, "sw5");
        run(32'h8C090014, 9, 32'h12340000, 32'h4C, "lw_b2b");
        run(32'h8C0A0114, 10, 32'h12340000, 32'h50, "lw_alias");

        dut.pminst.instr = 32'h20100007;
        reset = 1'b1;
        foreach (q[i]) begin end
        expect_v(K_REG, 4, 32'h0, "mid_r4");
        expect_v(K_REG, 6, 32'h0, "mid_r6");
        expect_v(K_REG, 15, 32'h0, "mid_r15");
        expect_v(K_REG, 16, 32'h0, "mid_r16");
        expect_v(K_PC, 0, 32'h0, "mid_pc");
        expect_v(K_INSTR, 0, 32'h0, "mid_instr");
        expect_v(K_RAM, 13, 32'h2345, "mid_ram13");
        @(negedge clk);
        reset = 1'b0;
        expect_v(K_PC, 0, 32'h04, "post_nop_pc");
        @(negedge clk);
        run(32'h20100007, 16, 32'h7, 32'h08, "post_addi");

        @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0",
                     q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
